// File: rtl/rr_arb.sv
// Round-robin arbiter: zero-latency one-hot grant, rotating priority that
// starts just past the last granted index and falls back to lowest-index-first when idle.
module rr_arb #(
  parameter int p_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  output logic [p_width-1:0] gnt
);

  localparam int IW = (p_width > 1) ? $clog2(p_width) : 1;

  // Interface contract: req/gnt is not a valid/ready pair. A requester holds
  // req[i] high while it wants service; gnt is valid combinationally in the
  // same cycle, and the grant counts as taken at the next rising clk edge.

  logic [IW-1:0]      last_q;
  logic               idle_q;
  logic [p_width-1:0] above_mask;
  logic [p_width-1:0] req_masked;
  logic [p_width-1:0] gnt_masked;
  logic [p_width-1:0] gnt_plain;
  logic [IW-1:0]      gnt_idx;

  // Keeps only the lowest set bit of v.
  function automatic logic [p_width-1:0] first_one(input logic [p_width-1:0] v);
    logic [p_width-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < p_width; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // An idle state leaves the mask empty, so only the plain encoder can win.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < p_width; i++) begin
      above_mask[i] = !idle_q && (i > int'(last_q));
    end
  end

  assign req_masked = req & above_mask;
  assign gnt_masked = first_one(req_masked);
  assign gnt_plain  = first_one(req);
  assign gnt        = (|req_masked) ? gnt_masked : gnt_plain;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < p_width; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= 1'b1;
      last_q <= '0;
    end else if (|gnt) begin
      idle_q <= 1'b0;
      last_q <= gnt_idx;
    end else begin
      idle_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// Directed and random checks of rr_arb at widths 1, 4, 8 and 32; expected
// grants are queued as stimulus is driven and popped when gnt is sampled.
module tb_rr_arb;

  logic        clk;
  logic        rst_n;
  logic [0:0]  req1;
  logic [3:0]  req4;
  logic [7:0]  req8;
  logic [31:0] req32;
  logic [0:0]  gnt1;
  logic [3:0]  gnt4;
  logic [7:0]  gnt8;
  logic [31:0] gnt32;

  logic [31:0] exp1_q[$];
  logic [31:0] exp4_q[$];
  logic [31:0] exp8_q[$];
  logic [31:0] exp32_q[$];

  int checks;
  int errors;

  // reference model state per width: index 0..3 -> widths 1,4,8,32
  bit m_idle [4];
  int m_last [4];

  rr_arb #(.p_width(1))  u_dut1  (.clk(clk), .rst(rst_n), .req(req1),  .gnt(gnt1));
  rr_arb #(.p_width(4))  u_dut4  (.clk(clk), .rst(rst_n), .req(req4),  .gnt(gnt4));
  rr_arb #(.p_width(8))  u_dut8  (.clk(clk), .rst(rst_n), .req(req8),  .gnt(gnt8));
  rr_arb #(.p_width(32)) u_dut32 (.clk(clk), .rst(rst_n), .req(req32), .gnt(gnt32));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_gnt(input logic [31:0] r, input int w,
                                            input bit idle, input int last);
    logic [31:0] g;
    int idx;
    g = '0;
    if (idle) begin
      for (int i = w - 1; i >= 0; i--) if (r[i]) g = 32'd1 << i;
    end else begin
      for (int k = w; k >= 1; k--) begin
        idx = (last + k) % w;
        if (r[idx]) g = 32'd1 << idx;
      end
    end
    return g;
  endfunction

  task automatic model_update(input int n, input logic [31:0] g);
    if (g == 0) begin
      m_idle[n] = 1'b1;
    end else begin
      m_idle[n] = 1'b0;
      for (int i = 0; i < 32; i++) if (g[i]) m_last[n] = i;
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_idle[n] = 1'b1;
      m_last[n] = 0;
    end
  endtask

  // scoreboard compare: pops one expectation from the selected queue
  task automatic check_pop(input int n, input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (n == 0 && exp1_q.size() > 0) exp = exp1_q.pop_front();
    else if (n == 1 && exp4_q.size() > 0) exp = exp4_q.pop_front();
    else if (n == 2 && exp8_q.size() > 0) exp = exp8_q.pop_front();
    else if (n == 3 && exp32_q.size() > 0) exp = exp32_q.pop_front();
    else begin
      errors++;
      $error("FAIL %s: no expectation queued, observed %h", tag, obs);
      return;
    end
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one p_width=4 directed cycle, starting just after a rising edge
  task automatic step4(input logic [3:0] r, input logic [3:0] e, input string tag);
    req4 = r;
    exp4_q.push_back({28'd0, e});
    @(negedge clk);
    check_pop(1, tag, {28'd0, gnt4});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_step(input int cyc);
    logic [31:0] r [4];
    logic [31:0] g [4];
    int w [4];
    w = '{1, 4, 8, 32};
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(0, 4) == 0) r[n] = '0;
      else r[n] = $urandom();
      if (w[n] < 32) r[n] = r[n] & ((32'd1 << w[n]) - 1);
      g[n] = model_gnt(r[n], w[n], m_idle[n], m_last[n]);
    end
    req1  = r[0][0:0];
    req4  = r[1][3:0];
    req8  = r[2][7:0];
    req32 = r[3];
    exp1_q.push_back(g[0]);
    exp4_q.push_back(g[1]);
    exp8_q.push_back(g[2]);
    exp32_q.push_back(g[3]);
    @(negedge clk);
    check_pop(0, $sformatf("rand_w1_c%0d", cyc),  {31'd0, gnt1});
    check_pop(1, $sformatf("rand_w4_c%0d", cyc),  {28'd0, gnt4});
    check_pop(2, $sformatf("rand_w8_c%0d", cyc),  {24'd0, gnt8});
    check_pop(3, $sformatf("rand_w32_c%0d", cyc), gnt32);
    @(posedge clk);
    for (int n = 0; n < 4; n++) model_update(n, g[n]);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    req1 = '0; req4 = '0; req8 = '0; req32 = '0;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    exp4_q.push_back(32'h0);
    check_pop(1, "rst_zero", {28'd0, gnt4});
    // lowest index wins while held in reset
    req4 = 4'b0110;
    exp4_q.push_back(32'h2);
    #1;
    check_pop(1, "rst_lowest", {28'd0, gnt4});
    req4 = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // after reset
    step4(4'b0000, 4'b0000, "ar_0");
    step4(4'b0001, 4'b0001, "ar_1");
    step4(4'b0010, 4'b0010, "ar_2");
    step4(4'b0011, 4'b0001, "ar_3");
    step4(4'b0011, 4'b0010, "ar_4");

    // idle and hold
    step4(4'b0000, 4'b0000, "ih_0");
    step4(4'b0000, 4'b0000, "ih_1");
    step4(4'b0001, 4'b0001, "ih_2");
    step4(4'b0001, 4'b0001, "ih_3");
    step4(4'b0000, 4'b0000, "ih_4");
    step4(4'b0000, 4'b0000, "ih_5");

    // rotation
    step4(4'b0001, 4'b0001, "rot_0");
    step4(4'b0111, 4'b0010, "rot_1");
    step4(4'b0111, 4'b0100, "rot_2");
    step4(4'b0111, 4'b0001, "rot_3");
    step4(4'b1111, 4'b0010, "rot_4");
    step4(4'b1111, 4'b0100, "rot_5");
    step4(4'b1111, 4'b1000, "rot_6");
    step4(4'b1111, 4'b0001, "rot_7");

    // shrinking set
    step4(4'b0001, 4'b0001, "shr_0");
    step4(4'b1110, 4'b0010, "shr_1");
    step4(4'b1110, 4'b0100, "shr_2");
    step4(4'b1110, 4'b1000, "shr_3");
    step4(4'b1100, 4'b0100, "shr_4");
    step4(4'b1100, 4'b1000, "shr_5");
    step4(4'b1000, 4'b1000, "shr_6");
    step4(4'b1000, 4'b1000, "shr_7");

    // async reset mid-cycle with L = 2
    step4(4'b0100, 4'b0100, "ars_setup");
    req4 = 4'b1111;
    exp4_q.push_back(32'h8);
    @(negedge clk);
    check_pop(1, "ars_before", {28'd0, gnt4});
    #1;
    rst_n = 1'b0;
    exp4_q.push_back(32'h1);
    #1;
    check_pop(1, "ars_during", {28'd0, gnt4});
    #1;
    rst_n = 1'b1;
    exp4_q.push_back(32'h1);
    #1;
    check_pop(1, "ars_released", {28'd0, gnt4});
    @(posedge clk);
    #1;
    step4(4'b1111, 4'b0010, "ars_after");

    // random across widths
    req4 = '0;
    do_reset();
    for (int c = 0; c < 30; c++) rand_step(c);
    do_reset();
    for (int c = 30; c < 55; c++) rand_step(c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb.md
RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001: Parameter p_width, default 4, number of requesters; legal range 1..32 minimum, and any positive width SHALL synthesize.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-low.
REQ-004: req  input  p_width  request vector; bit i = requester i wants a grant this cycle.
REQ-005: gnt  output  p_width  grant vector; one-hot or zero.

Function
REQ-006: gnt SHALL be a purely combinational function of req and the internal priority state; a grant is valid in the same cycle req is applied (zero-cycle latency).
REQ-007: gnt SHALL have at most one bit set; gnt SHALL be zero if and only if req is zero.
REQ-008: gnt[i] set SHALL imply req[i] set.
REQ-009: Internal state: last-granted index L, range 0..p_width-1, plus an "idle" value meaning no valid last grant.
REQ-010: Search order when L is valid: L+1, L+2, ..., p_width-1, then 0, 1, ..., L; first requesting index wins.
REQ-011: Search order when state is idle: 0, 1, ..., p_width-1, so the lowest requesting index wins.
REQ-012: On each rising clk edge with rst high and gnt non-zero, L SHALL become the index of the granted bit.
REQ-013: On each rising clk edge with rst high and gnt zero (req zero), state SHALL become idle.
REQ-014: A sole requester SHALL be granted every cycle it requests, including when it equals L (wrap-around to itself).
REQ-015: p_width = 1: gnt SHALL equal req every cycle.
REQ-016: Implementation guidance: two priority encoders, one over req masked to indices above L and one over unmasked req, selecting the masked result when it is non-zero; no multi-cycle logic, no handshake beyond req/gnt.

Reset
REQ-017: Asserting rst low SHALL immediately and asynchronously force state to idle, regardless of clk.
REQ-018: While rst is low, gnt SHALL still follow REQ-011 (lowest-index priority) combinationally; state SHALL not update.
REQ-019: Reset mid-operation SHALL discard L; the first post-reset grant SHALL go to the lowest requesting index.

Verification (p_width = 4 unless stated; one req value per cycle, gnt sampled before the next edge)
REQ-020: After reset: req 0000 -> gnt 0000; req 0001 -> 0001; req 0010 -> 0010; req 0011 -> 0001; req 0011 -> 0010.
REQ-021: Idle and hold: req 0000,0000,0001,0001,0000,0000 -> gnt 0000,0000,0001,0001,0000,0000.
REQ-022: Rotation: 0001 -> 0001; then 0111 held three cycles -> 0010, 0100, 0001; then 1111 held four cycles -> 0010, 0100, 1000, 0001.
REQ-023: Shrinking set: after last grant 0001, req 1110 held three cycles -> 0010, 0100, 1000; then 1100 held two cycles -> 0100, 1000; then 1000 held two cycles -> 1000, 1000.
REQ-024: Random: 20+ cycles of random req at p_width 1, 4, 8 and 32, checked against a reference model of REQ-010..REQ-013, including idle-reset of priority after any zero-req cycle.
REQ-025: Async reset: with L = 2, req 1111 held, pulse rst low between edges -> gnt changes immediately to 0001 and becomes 0010 after the next edge with rst high.
